// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line into the UART receiver and its received-byte outputs
// Ports: in_rx serial line (idle high); data_received last good byte;
//        done byte-valid pulse; frame_error bad-stop-bit pulse
interface uart_rx_if;
  logic       in_rx;
  logic [7:0] data_received;
  logic       done;
  logic       frame_error;
  modport master (output in_rx, input data_received, done, frame_error);
  modport slave (input in_rx, output data_received, done, frame_error);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-glitch rejection and stop-bit framing check
// Ports: clk board clock; rst_n async active-low reset;
//        bus.in_rx serial line in; bus.data_received last good byte;
//        bus.done / bus.frame_error registered one-cycle pulses
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208
) (
  input logic      clk,
  input logic      rst_n,
  uart_rx_if.slave bus
);
  localparam logic [12:0] HALF = 13'((CLKS_PER_BIT - 1) / 2);
  localparam logic [12:0] LAST = 13'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t      state, state_n;
  logic [1:0]  sync;
  logic        rx_s;
  logic [12:0] counter, counter_n;
  logic [2:0]  bit_index, bit_index_n;
  logic [7:0]  shift, shift_n, data_n;
  logic        done_n, frame_error_n;
  assign rx_s = sync[1];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync              <= 2'b11;
      state             <= IDLE;
      counter           <= '0;
      bit_index         <= '0;
      shift             <= '0;
      bus.data_received <= '0;
      bus.done          <= 1'b0;
      bus.frame_error   <= 1'b0;
    end else begin
      sync              <= {sync[0], bus.in_rx};
      state             <= state_n;
      counter           <= counter_n;
      bit_index         <= bit_index_n;
      shift             <= shift_n;
      bus.data_received <= data_n;
      bus.done          <= done_n;
      bus.frame_error   <= frame_error_n;
    end
  always_comb begin
    state_n       = IDLE;
    counter_n     = counter;
    bit_index_n   = bit_index;
    shift_n       = shift;
    data_n        = bus.data_received;
    done_n        = 1'b0;
    frame_error_n = 1'b0;
    case (state)
      IDLE: begin
        counter_n   = '0;
        bit_index_n = '0;
        state_n     = rx_s ? IDLE : START;
      end
      // mid-start-bit recheck: a line already back high was only a glitch
      START: begin
        counter_n = counter < HALF ? counter + 13'd1 : '0;
        state_n   = counter < HALF ? START : rx_s ? IDLE : DATA;
      end
      DATA: begin
        counter_n = counter < LAST ? counter + 13'd1 : '0;
        if (counter >= LAST) begin
          shift_n[bit_index] = rx_s;
          bit_index_n        = bit_index == 3'd7 ? bit_index : bit_index + 3'd1;
        end
        state_n = counter >= LAST && bit_index == 3'd7 ? STOP : DATA;
      end
      STOP: begin
        counter_n     = counter < LAST ? counter + 13'd1 : '0;
        done_n        = counter >= LAST && rx_s;
        frame_error_n = counter >= LAST && !rx_s;
        data_n        = done_n ? shift : bus.data_received;
        state_n       = counter < LAST ? STOP : rx_s ? IDLE : BRK;
      end
      // a held-low line after a bad stop must not look like a fresh start bit
      BRK: state_n = rx_s ? IDLE : BRK;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx against a frame-level model
module tb_uart_rx;
  localparam int CPB = 16;
  localparam int LAT = 1 + 3 + (CPB - 1) / 2 + 9 * CPB;
  typedef struct {
    int         cyc;
    logic       fe;
    logic [7:0] data;
  } ev_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         n_done = 0;
  int         n_fe = 0;
  int         last_done = 0;
  int         last_fe = 0;
  int         done_times[$];
  ev_t        q[$];
  logic [7:0] exp_data;
  logic       ed, ef;
  bit         armed = 0;
  uart_rx_if bus ();
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask
  task automatic idle(input int n);
    bus.in_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask
  // Drives one frame starting at the current negedge; the pulse it causes is
  // expected LAT cycles later (edge 0 is the next posedge).
  task automatic send(input logic [7:0] b, input logic stop, input int hold,
                      input bit expect_ev, output int st);
    ev_t e;
    st = cyc;
    e.cyc = cyc + LAT;
    e.fe = !stop;
    e.data = b;
    if (expect_ev) q.push_back(e);
    bus.in_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.in_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    bus.in_rx = stop;
    repeat (CPB + hold) @(negedge clk);
    bus.in_rx = 1'b1;
  endtask
  task automatic glitch(input int len);
    bus.in_rx = 1'b0;
    repeat (len) @(negedge clk);
    idle(20);
  endtask
  initial begin
    int st, d0, f0, r;
    bus.in_rx = 1'b1;
    exp_data = '0;
    fork
      forever begin
        @(negedge clk);
        if (armed) begin
          ed = 1'b0;
          ef = 1'b0;
          if (q.size() > 0 && q[0].cyc == cyc) begin
            ef = q[0].fe;
            ed = !q[0].fe;
            if (ed) exp_data = q[0].data;
            void'(q.pop_front());
          end
          chk("done", {31'b0, bus.done}, {31'b0, ed});
          chk("frame_error", {31'b0, bus.frame_error}, {31'b0, ef});
          chk("data_received", {24'b0, bus.data_received}, {24'b0, exp_data});
          if (bus.done) begin
            n_done++;
            last_done = cyc;
            done_times.push_back(cyc);
          end
          if (bus.frame_error) begin
            n_fe++;
            last_fe = cyc;
          end
        end
      end
    join_none
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    armed = 1;
    #1;
    chk("reset data_received", {24'b0, bus.data_received}, 32'h0);
    chk("reset done", {31'b0, bus.done}, 32'h0);
    chk("reset frame_error", {31'b0, bus.frame_error}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1000);
    chk("idle done count", n_done, 0);
    chk("idle frame_error count", n_fe, 0);
    send(8'hA5, 1'b1, 0, 1, st);
    idle(5);
    chk("A5 data", {24'b0, bus.data_received}, 32'hA5);
    chk("A5 latency", last_done - st, 155);
    chk("A5 done count", n_done, 1);
    chk("A5 frame_error count", n_fe, 0);
    send(8'h00, 1'b1, 0, 1, st);
    send(8'hFF, 1'b1, 0, 1, st);
    idle(5);
    chk("b2b done count", n_done, 3);
    chk("b2b spacing", done_times[$] - done_times[$-1], 160);
    chk("b2b last data", {24'b0, bus.data_received}, 32'hFF);
    glitch(3);
    chk("glitch no pulse", n_done + n_fe, 3);
    send(8'h3C, 1'b1, 0, 1, st);
    idle(5);
    chk("3C data", {24'b0, bus.data_received}, 32'h3C);
    send(8'h11, 1'b1, 0, 1, st);
    idle(5);
    d0 = n_done;
    f0 = n_fe;
    send(8'h55, 1'b0, 40, 1, st);
    idle(5);
    chk("ferr count", n_fe, f0 + 1);
    chk("ferr no done", n_done, d0);
    chk("ferr latency", last_fe - st, 155);
    chk("ferr data held", {24'b0, bus.data_received}, 32'h11);
    send(8'h81, 1'b1, 0, 1, st);
    idle(5);
    chk("81 data", {24'b0, bus.data_received}, 32'h81);
    send(8'h42, 1'b1, 0, 1, st);
    idle(5);
    chk("42 data", {24'b0, bus.data_received}, 32'h42);
    d0 = n_done;
    f0 = n_fe;
    fork
      send(8'hF8, 1'b1, 0, 1, st);
      begin
        repeat (CPB * 4 + CPB / 2) @(negedge clk);
        #3 rst_n = 1'b0;
        q.delete();
        exp_data = '0;
        #1;
        chk("midframe reset data", {24'b0, bus.data_received}, 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
      end
    join
    idle(20);
    chk("midframe reset no pulse", n_done + n_fe, d0 + f0);
    send(8'h7E, 1'b1, 0, 1, st);
    idle(5);
    chk("7E data", {24'b0, bus.data_received}, 32'h7E);
    chk("7E done count", n_done, d0 + 1);
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        send(8'($urandom), 1'b1, 0, 1, st);
        idle($urandom_range(0, 20));
      end else if (r < 8) begin
        glitch($urandom_range(1, 7));
      end else begin
        send(8'($urandom), 1'b0, $urandom_range(0, 40), 1, st);
        idle($urandom_range(4, 20));
      end
    end
    idle(200);
    chk("outstanding events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous UART receiver: the downstream counterpart of the board's UART transmitter. It oversamples the serial line with the 50 MHz board clock and deserialises 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). Each received byte is presented on a parallel bus with a one-cycle `done` strobe, for consumption by the command decoder. Glitches on the start bit are rejected, and bad stop bits are flagged.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 000 000 / 9600). Legal range 4..8191.
- `clk`  in  1  board clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low. One clock; reset is asynchronous and active-low.
- `in_rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `data_received`  out  8  last correctly framed byte; held until the next good frame.
- `done`  out  1  one-cycle pulse; `data_received` is valid in the same cycle.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.

## Operation
- **Synchroniser.** `in_rx` passes through a 2-flop synchroniser, giving `rx_s`. Both flops reset to 1.
- **Constants and counters.**
  - `HALF = (CLKS_PER_BIT-1)/2`, integer division.
  - 13-bit cycle counter `counter`.
  - 3-bit `bit_index`.
  - 8-bit shift register `shift`.
- **States** (3-bit encoding): IDLE, START, DATA, STOP, BREAK. Any unused encoding goes to IDLE.
- **IDLE.**
  - `counter` = 0 and `bit_index` = 0.
  - `rx_s`=0 → START.
- **START.**
  - While `counter < HALF`: increment `counter`.
  - At `counter == HALF`: if `rx_s`=0, then `counter` = 0 → DATA.
  - If `rx_s`=1 at that point, the start is false: → IDLE with no pulse.
- **DATA.**
  - While `counter < CLKS_PER_BIT-1`: increment `counter`.
  - Otherwise `shift[bit_index] <= rx_s` and `counter` = 0.
  - If `bit_index`=7 → STOP; else increment `bit_index`.
- **STOP.** Count the same way. At `counter == CLKS_PER_BIT-1`, sample `rx_s`:
  - `rx_s`=1: `data_received <= shift`, `done` = 1 for one cycle → IDLE.
  - `rx_s`=0: `frame_error` = 1 for one cycle, `data_received` unchanged → BREAK.
- **BREAK.** Stay until `rx_s`=1, then → IDLE. This prevents a held-low line (break) from being taken as a new start bit.
- **Pulse rules.** `done` and `frame_error` are registered, mutually exclusive, and never high for more than one cycle.
- **Reset values.**
  - State IDLE.
  - `counter`, `bit_index`, `shift`, `data_received` = 0.
  - `done`, `frame_error` = 0.
  - Synchroniser flops = 1.
- **Reset mid-frame.** The frame is abandoned with no pulse. After release, remaining low data bits on the line may start a spurious frame. That frame ends in `frame_error` or a junk byte. This is accepted behaviour; the upper protocol layer handles recovery.

## Timing
- Edge 0 is the first `clk` edge at which `in_rx` is sampled low by the first sync flop.
  - `rx_s` is low after edge 1.
  - START is entered at edge 2.
- The start-bit check happens at edge `3+HALF`.
- Data bit k is sampled at edge `3+HALF+(k+1)*CLKS_PER_BIT`, k = 0..7.
- The stop bit is sampled, and `done`/`frame_error` is registered, at edge `3+HALF+9*CLKS_PER_BIT`. The output is high for the following cycle only.
  - With `CLKS_PER_BIT`=16 (HALF=7), this is edge 154.
- Back-to-back frames are supported. The stop-bit sample is mid-stop-bit, so IDLE is re-entered about `CLKS_PER_BIT/2` cycles before the next start edge.
- Tolerated baud mismatch: about ±4 % total.
- A start glitch shorter than `HALF+1` cycles, measured at `rx_s`, is rejected.

## Test plan
Tests 2–6 use `CLKS_PER_BIT`=16.
1. **Reset and idle.** Assert `rst_n`=0 mid-cycle, then hold `in_rx`=1 for 1000 cycles → all outputs 0 immediately on reset; no `done` or `frame_error` pulses.
2. **Single byte.** Send 0xA5 → `done` high exactly one cycle, after edge 154 from the first low sample; `data_received`=0xA5; `frame_error`=0.
3. **Back-to-back frames.** Send 0x00 then 0xFF with zero idle between them → two `done` pulses, 160 cycles apart, with `data_received` 0x00 then 0xFF.
4. **Start glitch.** Drive `in_rx` low for 3 cycles, then high; then send 0x3C → no pulse from the glitch; the FSM returns to IDLE; 0x3C is then received correctly.
5. **Framing error.** Receive 0x11 first. Then send 0x55 with the stop bit low and the line held low for 40 further cycles → one `frame_error` pulse; no `done`; `data_received` stays 0x11; no new frame starts until the line is high. A following 0x81 is received correctly.
6. **Reset mid-frame.** Pulse `rst_n` low during data bit 3, after a prior 0x42 was received → `data_received`=0 immediately and no pulse. After line idle, send 0x7E → `data_received`=0x7E with one `done` pulse.
